// File: rtl/mvm_engine.sv
// Matrix-vector multiply core: y = A*x over external sync-read memories, one MAC per cycle.
// Optional MVM_SATURATE_EN: saturating accumulator with sticky ovf flag.
module mvm_engine #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned MAX_ROWS = 16,
  parameter int unsigned MAX_COLS = 16,
  localparam int unsigned RA_W    = $clog2(MAX_ROWS),
  localparam int unsigned CA_W    = $clog2(MAX_COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [RA_W:0]          num_rows,
  input  logic [CA_W:0]          num_cols,
  output logic [RA_W+CA_W-1:0]   mat_addr,
  output logic [CA_W-1:0]        vec_addr,
  input  logic [DATA_W-1:0]      mat_rd_data,
  input  logic [DATA_W-1:0]      vec_rd_data,
  output logic                   res_we,
  output logic [RA_W-1:0]        res_addr,
  output logic [ACC_W-1:0]       res_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                   state;
  logic [RA_W:0]            rows_q;
  logic [CA_W:0]            cols_q;
  logic [RA_W-1:0]          row;
  logic [CA_W-1:0]          col;
  logic signed [ACC_W-1:0]  acc;
  logic                     vld;

  logic [RA_W:0]            rows_in;
  logic [CA_W:0]            cols_in;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     clamp;
  logic                     last_col;
  logic                     last_row;

  // Counts above the compile-time maxima run at the maximum
  assign rows_in = (num_rows > (RA_W+1)'(MAX_ROWS)) ? (RA_W+1)'(MAX_ROWS) : num_rows;
  assign cols_in = (num_cols > (CA_W+1)'(MAX_COLS)) ? (CA_W+1)'(MAX_COLS) : num_cols;

  assign prod     = $signed(mat_rd_data) * $signed(vec_rd_data);
  assign prod_ext = ACC_W'(prod);
  assign last_col = ({1'b0, col} == (cols_q - (CA_W+1)'(1)));
  assign last_row = ({1'b0, row} == (rows_q - (RA_W+1)'(1)));

`ifdef MVM_SATURATE_EN
  logic signed [ACC_W:0] wide;
  always_comb begin
    wide    = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    clamp   = wide[ACC_W] ^ wide[ACC_W-1];
    acc_sum = wide[ACC_W-1:0];
    if (clamp)
      acc_sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  always_comb begin
    clamp   = 1'b0;
    acc_sum = acc + prod_ext;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      row      <= '0;
      col      <= '0;
      acc      <= '0;
      vld      <= 1'b0;
      mat_addr <= '0;
      vec_addr <= '0;
      res_we   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      res_we <= 1'b0;
      done   <= 1'b0;
      // Read data arrives one cycle after each RUN address
      vld    <= (state == S_RUN);
      if (vld) begin
        acc <= acc_sum;
        ovf <= ovf | clamp;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            rows_q <= rows_in;
            cols_q <= cols_in;
            row    <= '0;
            col    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
            ovf    <= 1'b0;
            state  <= (rows_in == '0 || cols_in == '0) ? S_DONE : S_CLR;
          end
        end
        S_CLR: begin
          acc      <= '0;
          col      <= '0;
          mat_addr <= {row, CA_W'(0)};
          vec_addr <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (last_col) begin
            state <= S_DRAIN;
          end else begin
            col      <= col + CA_W'(1);
            mat_addr <= {row, col + CA_W'(1)};
            vec_addr <= col + CA_W'(1);
          end
        end
        S_DRAIN: begin
          res_we   <= 1'b1;
          res_addr <= row;
          res_data <= acc_sum;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (last_row) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            row   <= row + RA_W'(1);
            state <= S_CLR;
          end
        end
        S_DONE: begin
          // A zero-count run arrives here without done raised yet
          if (!done) begin
            done <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_engine.sv
// Directed self-checking bench for mvm_engine (default build and MVM_SATURATE_EN build).
module tb_mvm_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_s;
  logic [4:0]  num_rows, num_cols, rows_s, cols_s;
  logic [7:0]  mat_addr, mat_addr_s;
  logic [3:0]  vec_addr, vec_addr_s;
  logic [7:0]  a_rd, x_rd, a_rd_s, x_rd_s;
  logic        res_we, res_we_s;
  logic [3:0]  res_addr, res_addr_s;
  logic [23:0] res_data;
  logic [15:0] res_data_s;
  logic        busy, done, ovf, busy_s, done_s, ovf_s;

  logic [7:0] mem_a [256];
  logic [7:0] mem_x [16];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int s_cnt = 0;
  int e;
  logic [3:0]         wq_addr [$];
  logic signed [23:0] wq_data [$];
  logic signed [15:0] s_data;

  always #5 clk = ~clk;

  mvm_engine u_dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .mat_addr(mat_addr), .vec_addr(vec_addr), .mat_rd_data(a_rd), .vec_rd_data(x_rd),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done), .ovf(ovf)
  );

  mvm_engine #(.ACC_W(16)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .num_rows(rows_s), .num_cols(cols_s),
    .mat_addr(mat_addr_s), .vec_addr(vec_addr_s), .mat_rd_data(a_rd_s), .vec_rd_data(x_rd_s),
    .res_we(res_we_s), .res_addr(res_addr_s), .res_data(res_data_s),
    .busy(busy_s), .done(done_s), .ovf(ovf_s)
  );

  // Synchronous-read memories, one read port per engine
  always @(posedge clk) begin
    a_rd   <= mem_a[mat_addr];
    x_rd   <= mem_x[vec_addr];
    a_rd_s <= mem_a[mat_addr_s];
    x_rd_s <= mem_x[vec_addr_s];
  end

  always @(negedge clk) begin
    if (res_we) begin
      wq_addr.push_back(res_addr);
      wq_data.push_back(res_data);
    end
    if (done) done_cnt++;
    if (res_we_s) begin
      s_data = res_data_s;
      s_cnt++;
    end
  end

  task automatic chk(input string tag, input integer obs, input integer exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input int r, input int c);
    @(negedge clk);
    num_rows = 5'(r);
    num_cols = 5'(c);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < lim) begin
      step(1);
      edges++;
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    done_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    num_rows = '0; num_cols = '0; rows_s = '0; cols_s = '0;
    for (int i = 0; i < 256; i++) mem_a[i] = '0;
    for (int i = 0; i < 16; i++) mem_x[i] = '0;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", res_we, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_maddr", mat_addr, 0);
    @(negedge clk) rst = 1'b0;

    // 2x2 basic
    mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[16] = 8'd3; mem_a[17] = 8'd4;
    mem_x[0] = 8'd5; mem_x[1] = 8'd6;
    clear_log();
    go(2, 2);
    chk("t1_busy_e0", busy, 1);
    step(9);
    chk("t1_done_e9", done, 0);
    step(1);
    chk("t1_done_e10", done, 1);
    chk("t1_busy_e10", busy, 1);
    step(1);
    chk("t1_busy_e11", busy, 0);
    chk("t1_nwr", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      chk("t1_a0", wq_addr[0], 0);
      chk("t1_d0", wq_data[0], 17);
      chk("t1_a1", wq_addr[1], 1);
      chk("t1_d1", wq_data[1], 39);
    end

    // signed 1x2
    mem_a[0] = 8'(-3); mem_a[1] = 8'd4;
    mem_x[0] = 8'd2;   mem_x[1] = 8'(-1);
    clear_log();
    go(1, 2);
    step(4);
    chk("t2_done_e4", done, 0);
    step(1);
    chk("t2_done_e5", done, 1);
    step(1);
    chk("t2_nwr", wq_addr.size(), 1);
    if (wq_data.size() == 1) chk("t2_d0", wq_data[0], -10);

    // zero columns
    clear_log();
    go(4, 0);
    chk("t3_busy_e0", busy, 1);
    chk("t3_done_e0", done, 0);
    step(1);
    chk("t3_done_e1", done, 1);
    step(1);
    chk("t3_busy_e2", busy, 0);
    step(5);
    chk("t3_nwr", wq_addr.size(), 0);
    chk("t3_ndone", done_cnt, 1);

    // 3x3 with start pulsed mid-run
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mem_a[r*16+c] = 8'(r*3 + c + 1);
    for (int c = 0; c < 3; c++) mem_x[c] = 8'd1;
    clear_log();
    go(3, 3);
    step(4);
    @(negedge clk);
    num_rows = 5'd1; num_cols = 5'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60, e);
    chk("t4_done_edge", e + 5, 18);
    step(4);
    chk("t4_nwr", wq_addr.size(), 3);
    chk("t4_ndone", done_cnt, 1);
    if (wq_data.size() == 3) begin
      chk("t4_d0", wq_data[0], 6);
      chk("t4_d1", wq_data[1], 15);
      chk("t4_d2", wq_data[2], 24);
      chk("t4_a2", wq_addr[2], 2);
    end

    // reset during row 1 of a 4x4 run
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mem_a[r*16+c] = 8'd1;
    for (int c = 0; c < 4; c++) mem_x[c] = 8'd1;
    clear_log();
    go(4, 4);
    step(9);
    rst = 1'b1;
    step(1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_we", res_we, 0);
    chk("t5_maddr", mat_addr, 0);
    chk("t5_vaddr", vec_addr, 0);
    chk("t5_raddr", res_addr, 0);
    chk("t5_rdata", res_data, 0);
    chk("t5_ovf", ovf, 0);
    rst = 1'b0;
    step(40);
    chk("t5_nwr", wq_addr.size(), 1);
    chk("t5_ndone", done_cnt, 0);
    if (wq_data.size() == 1) chk("t5_d0", wq_data[0], 4);

    // fresh run after reset: A[r][c]=r+c, x=c+1
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mem_a[r*16+c] = 8'(r + c);
    for (int c = 0; c < 4; c++) mem_x[c] = 8'(c + 1);
    clear_log();
    go(4, 4);
    wait_done(60, e);
    chk("t6_done_edge", e, 28);
    step(2);
    chk("t6_nwr", wq_addr.size(), 4);
    if (wq_data.size() == 4) begin
      chk("t6_d0", wq_data[0], 20);
      chk("t6_d1", wq_data[1], 30);
      chk("t6_d2", wq_data[2], 40);
      chk("t6_d3", wq_data[3], 50);
      chk("t6_a3", wq_addr[3], 3);
    end

    // column count above maximum runs 16 columns
    clear_log();
    go(1, 31);
    wait_done(60, e);
    chk("t7_clamp_edge", e, 19);
    step(2);

    // 16-bit accumulator overflow
    for (int c = 0; c < 3; c++) begin
      mem_a[c] = 8'd127;
      mem_x[c] = 8'd127;
    end
    @(negedge clk);
    rows_s = 5'd1; cols_s = 5'd3; start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    step(6);
    chk("t8_done_e6", done_s, 1);
    chk("t8_nwr", s_cnt, 1);
`ifdef MVM_SATURATE_EN
    chk("t8_res", s_data, 32767);
    chk("t8_ovf", ovf_s, 1);
`else
    chk("t8_res", s_data, -17149);
    chk("t8_ovf", ovf_s, 0);
`endif
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
